if_id_fetch_stage: RTL and testbench

Instruction-fetch front end and IF/ID pipeline register for the PPU pipeline.
- Holds the MIPS PC/nPC pair and addresses the instruction memory.
- Latches the fetched word and its PC into the IF/ID register that feeds the decode control unit.
- Applies branch/jump target redirects with one architectural delay slot.
- Supports stall (load-enable) and exception-style flush.

---
 rtl/if_id_fetch_stage.sv | 64 ++++++
 tb/tb_if_id_fetch_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch front end: MIPS PC/nPC pair with one delay slot, feeding
// the IF/ID pipeline register. Priority per edge is flush > stall > normal.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              le,
  input  logic              ta_valid,
  input  logic              flush,
  input  logic [31:0]       target_addr,
  input  logic [31:0]       imem_data,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       pc_out,
  output logic [31:0]       npc_out,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc,
  output logic              if_id_valid,
  output logic [31:0]       fetch_count
);

  localparam logic [31:0] WORD_STEP = 32'd4;

  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] target_aligned;

  // Targets and flush vectors are word addresses; the low two bits are dropped.
  assign target_aligned = {target_addr[31:2], 2'b00};

  // Fetch aliases beyond the memory size: only the low address bits are used.
  assign imem_addr = pc[ADDR_W-1:0];
  assign pc_out    = pc;
  assign npc_out   = npc;

  // NOTE: every register here uses non-blocking assignments so that the
  // delay-slot fetch reads the pre-edge nPC while the new nPC is computed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      npc         <= RESET_PC + WORD_STEP;
      if_id_instr <= 32'h0;
      if_id_pc    <= 32'h0;
      if_id_valid <= 1'b0;
      fetch_count <= 32'h0;
    end else if (flush) begin
      // Redirect takes effect at once; the IF/ID slot becomes a NOP bubble.
      pc          <= target_aligned;
      npc         <= target_aligned + WORD_STEP;
      if_id_instr <= 32'h0;
      if_id_pc    <= 32'h0;
      if_id_valid <= 1'b0;
    end else if (le) begin
      if_id_instr <= imem_data;
      if_id_pc    <= pc;
      if_id_valid <= 1'b1;
      pc          <= npc;
      npc         <= ta_valid ? target_aligned : npc + WORD_STEP;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Self-checking bench for if_id_fetch_stage: directed vector table, hand-written
// reset/wrap sequences, then random stimulus against a fetch-queue model.
module tb_if_id_fetch_stage;

  localparam int ADDR_W = 9;

  typedef struct {
    logic        le;
    logic        ta;
    logic        fl;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] ifpc;
    logic        valid;
    logic [31:0] cnt;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset_n, le, ta_valid, flush;
  logic [31:0]       target_addr, imem_data;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       pc_out, npc_out, if_id_instr, if_id_pc, fetch_count;
  logic              if_id_valid;

  logic              rst_w;
  logic [31:0]       imem_data_w;
  logic [ADDR_W-1:0] imem_addr_w;
  logic [31:0]       pc_w, npc_w, instr_w, ifpc_w, cnt_w;
  logic              valid_w;

  int vectors    = 0;
  int miscompares = 0;

  vec_t tbl[18];

  // Model: the upcoming fetch addresses (front = PC, next = nPC) plus IF/ID.
  logic [31:0] fq[$];
  logic [31:0] m_instr, m_ifpc, m_cnt;
  logic        m_valid;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return {7'h55, a, 7'h2a, ~a};
  endfunction

  assign imem_data   = mem_word(imem_addr);
  assign imem_data_w = mem_word(imem_addr_w);

  if_id_fetch_stage #(.RESET_PC(32'h0000_0000), .ADDR_W(ADDR_W)) u_dut (
    .clk(clk), .reset_n(reset_n), .le(le), .ta_valid(ta_valid), .flush(flush),
    .target_addr(target_addr), .imem_data(imem_data), .imem_addr(imem_addr),
    .pc_out(pc_out), .npc_out(npc_out), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .if_id_valid(if_id_valid), .fetch_count(fetch_count)
  );

  if_id_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .ADDR_W(ADDR_W)) u_wrap (
    .clk(clk), .reset_n(rst_w), .le(1'b1), .ta_valid(1'b0), .flush(1'b0),
    .target_addr(32'h0), .imem_data(imem_data_w), .imem_addr(imem_addr_w),
    .pc_out(pc_w), .npc_out(npc_w), .if_id_instr(instr_w),
    .if_id_pc(ifpc_w), .if_id_valid(valid_w), .fetch_count(cnt_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_main(input string tag, input logic [31:0] pc, input logic [31:0] npc,
                            input logic [31:0] ifpc, input logic valid, input logic [31:0] cnt);
    logic [31:0] exp_instr;
    exp_instr = valid ? mem_word(ifpc[ADDR_W-1:0]) : 32'h0;
    check({tag, " pc_out"},      pc_out,      pc);
    check({tag, " npc_out"},     npc_out,     npc);
    check({tag, " imem_addr"},   {23'h0, imem_addr}, {23'h0, pc[ADDR_W-1:0]});
    check({tag, " if_id_pc"},    if_id_pc,    ifpc);
    check({tag, " if_id_valid"}, {31'h0, if_id_valid}, {31'h0, valid});
    check({tag, " if_id_instr"}, if_id_instr, exp_instr);
    check({tag, " fetch_count"}, fetch_count, cnt);
  endtask

  task automatic check_wrap(input string tag, input logic [31:0] pc, input logic [31:0] npc,
                            input logic [31:0] ifpc, input logic valid, input logic [31:0] cnt);
    logic [31:0] exp_instr;
    exp_instr = valid ? mem_word(ifpc[ADDR_W-1:0]) : 32'h0;
    check({tag, " pc_out"},      pc_w,    pc);
    check({tag, " npc_out"},     npc_w,   npc);
    check({tag, " if_id_pc"},    ifpc_w,  ifpc);
    check({tag, " if_id_valid"}, {31'h0, valid_w}, {31'h0, valid});
    check({tag, " if_id_instr"}, instr_w, exp_instr);
    check({tag, " fetch_count"}, cnt_w,   cnt);
  endtask

  task automatic model_reset();
    fq.delete();
    fq.push_back(32'h0);
    fq.push_back(32'h4);
    m_instr = 32'h0;
    m_ifpc  = 32'h0;
    m_valid = 1'b0;
    m_cnt   = 32'h0;
  endtask

  task automatic model_edge(input logic l, input logic t, input logic f, input logic [31:0] tgt);
    logic [31:0] al, cur;
    al = tgt & 32'hFFFF_FFFC;
    if (f) begin
      fq.delete();
      fq.push_back(al);
      fq.push_back(al + 32'd4);
      m_instr = 32'h0;
      m_ifpc  = 32'h0;
      m_valid = 1'b0;
    end else if (l) begin
      cur     = fq.pop_front();
      m_instr = mem_word(cur[ADDR_W-1:0]);
      m_ifpc  = cur;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 32'd1;
      fq.push_back(t ? al : fq[0] + 32'd4);
    end
  endtask

  initial begin
    //          le  ta  fl  target        pc            npc           ifpc          v  cnt
    tbl[0]  = '{1, 0, 0, 32'h0,  32'h04, 32'h08, 32'h00, 1, 32'd1};
    tbl[1]  = '{1, 0, 0, 32'h0,  32'h08, 32'h0C, 32'h04, 1, 32'd2};
    tbl[2]  = '{1, 1, 0, 32'h40, 32'h0C, 32'h40, 32'h08, 1, 32'd3};
    tbl[3]  = '{1, 0, 0, 32'h0,  32'h40, 32'h44, 32'h0C, 1, 32'd4};
    tbl[4]  = '{1, 0, 0, 32'h0,  32'h44, 32'h48, 32'h40, 1, 32'd5};
    tbl[5]  = '{1, 0, 1, 32'h0F, 32'h0C, 32'h10, 32'h00, 0, 32'd5};
    tbl[6]  = '{1, 0, 0, 32'h0,  32'h10, 32'h14, 32'h0C, 1, 32'd6};
    tbl[7]  = '{0, 0, 0, 32'h0,  32'h10, 32'h14, 32'h0C, 1, 32'd6};
    tbl[8]  = '{0, 0, 0, 32'h0,  32'h10, 32'h14, 32'h0C, 1, 32'd6};
    tbl[9]  = '{0, 0, 0, 32'h0,  32'h10, 32'h14, 32'h0C, 1, 32'd6};
    tbl[10] = '{1, 0, 0, 32'h0,  32'h14, 32'h18, 32'h10, 1, 32'd7};
    tbl[11] = '{0, 1, 0, 32'h80, 32'h14, 32'h18, 32'h10, 1, 32'd7};
    tbl[12] = '{0, 1, 0, 32'h80, 32'h14, 32'h18, 32'h10, 1, 32'd7};
    tbl[13] = '{1, 1, 0, 32'h80, 32'h18, 32'h80, 32'h14, 1, 32'd8};
    tbl[14] = '{1, 0, 0, 32'h0,  32'h80, 32'h84, 32'h18, 1, 32'd9};
    tbl[15] = '{1, 0, 0, 32'h0,  32'h84, 32'h88, 32'h80, 1, 32'd10};
    tbl[16] = '{0, 1, 1, 32'h83, 32'h80, 32'h84, 32'h00, 0, 32'd10};
    tbl[17] = '{1, 0, 0, 32'h0,  32'h84, 32'h88, 32'h80, 1, 32'd11};

    reset_n = 1'b0; rst_w = 1'b0;
    le = 1'b0; ta_valid = 1'b0; flush = 1'b0; target_addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_main("reset", 32'h0, 32'h4, 32'h0, 1'b0, 32'd0);
    check_wrap("wrap_reset", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'd0);

    // Directed table: sequential fetch, delay slot, stall, pending redirect, flush priority.
    reset_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      le = tbl[i].le; ta_valid = tbl[i].ta; flush = tbl[i].fl; target_addr = tbl[i].target;
      @(posedge clk);
      #1;
      check_main($sformatf("tbl%0d", i), tbl[i].pc, tbl[i].npc, tbl[i].ifpc, tbl[i].valid, tbl[i].cnt);
    end

    // Async reset in the middle of a redirect: no edge needed to clear state.
    le = 1'b1; ta_valid = 1'b1; flush = 1'b0; target_addr = 32'h200;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_main("async_mid_redirect", 32'h0, 32'h4, 32'h0, 1'b0, 32'd0);
    le = 1'b0; ta_valid = 1'b0;

    // PC/nPC wrap on the second instance, then async reset between edges.
    rst_w = 1'b1;
    @(posedge clk); #1 check_wrap("wrap1", 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFF8, 1'b1, 32'd1);
    @(posedge clk); #1 check_wrap("wrap2", 32'h0, 32'h4, 32'hFFFF_FFFC, 1'b1, 32'd2);
    @(posedge clk); #1 check_wrap("wrap3", 32'h4, 32'h8, 32'h0, 1'b1, 32'd3);
    #2 rst_w = 1'b0;
    #1 check_wrap("wrap_async", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'd0);

    // Async reset during a stall on the main instance.
    reset_n = 1'b1; le = 1'b1;
    repeat (3) @(posedge clk);
    #1 le = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_main("async_mid_stall", 32'h0, 32'h4, 32'h0, 1'b0, 32'd0);

    // Random phase against the fetch-queue model.
    model_reset();
    reset_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      le          = ($urandom_range(0, 3) != 0);
      ta_valid    = ($urandom_range(0, 4) == 0);
      flush       = ($urandom_range(0, 19) == 0);
      target_addr = $urandom();
      @(posedge clk);
      model_edge(le, ta_valid, flush, target_addr);
      #1;
      check_main($sformatf("rand%0d", c), fq[0], fq[1], m_ifpc, m_valid, m_cnt);
      check($sformatf("rand%0d instr_model", c), if_id_instr, m_instr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
